// File: rtl/fft_stage_sequencer_pkg.sv
// Shared types and sizing helpers for the FFT stage III/IV timing sequencer.
package fft_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL3 = 2'd1,
    FILL4 = 2'd2,
    RUN   = 2'd3
  } seq_state_e;

  localparam int DLY3_DEF    = 8;
  localparam int DLY4_DEF    = 4;
  localparam int FRAME_W_DEF = 16;

  function automatic int addr_w(input int dly);
    return $clog2(2 * dly);
  endfunction

  localparam int ADDR3_W = addr_w(DLY3_DEF);
  localparam int ADDR4_W = addr_w(DLY4_DEF);

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Control bundle between the sequencer (master) and the FFT datapath (slave).
interface fft_stage_sequencer_if
  import fft_seq_pkg::*;
#(
  parameter int A3W     = ADDR3_W,
  parameter int A4W     = ADDR4_W,
  parameter int FRAME_W = FRAME_W_DEF
);
  logic               in_enable;
  logic               stage3_en;
  logic               ctrl3;
  logic [A3W-1:0]     coeff_addr3;
  logic               stage4_en;
  logic               ctrl4;
  logic [A4W-1:0]     coeff_addr4;
  logic               out_valid;
  logic               busy;
  logic [FRAME_W-1:0] frame_cnt;
  logic               sof;

  modport master (
    input  in_enable,
    output stage3_en, ctrl3, coeff_addr3, stage4_en, ctrl4, coeff_addr4,
    output out_valid, busy, frame_cnt, sof
  );

  modport slave (
    output in_enable,
    input  stage3_en, ctrl3, coeff_addr3, stage4_en, ctrl4, coeff_addr4,
    input  out_valid, busy, frame_cnt, sof
  );
endinterface

// File: rtl/fft_stage_sequencer_stage_timer.sv
// Per-stage timer: fill counter plus the k counter that yields enable, Blq ctrl and ROM address.
module fft_seq_stage_timer
  import fft_seq_pkg::*;
#(
  parameter int DLY       = 8,
  parameter int FILL_LAST = 7,
  localparam int AW       = addr_w(DLY)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill_i,
  input  logic          en_d_i,
  output logic          fill_last_o,
  output logic          stage_en_o,
  output logic          ctrl_o,
  output logic [AW-1:0] addr_o
);

  logic [AW-1:0] fill_cnt_q, fill_cnt_d;
  logic [AW-1:0] k_q, k_d;
  logic          stage_en_q;

  // next-state for fill and k counters; k restarts at 0 on the first enabled cycle
  always_comb begin
    fill_cnt_d  = '0;
    k_d         = '0;
    fill_last_o = 1'b0;
    if (fill_i) begin
      fill_cnt_d  = fill_cnt_q + AW'(1);
      fill_last_o = (fill_cnt_q == AW'(FILL_LAST));
    end else begin
      fill_cnt_d  = '0;
      fill_last_o = 1'b0;
    end
    if (en_d_i && stage_en_q) begin
      k_d = k_q + AW'(1);
    end else begin
      k_d = '0;
    end
  end

  // counter and enable registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt_q <= '0;
      k_q        <= '0;
      stage_en_q <= 1'b0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      k_q        <= k_d;
      stage_en_q <= en_d_i;
    end
  end

  assign stage_en_o = stage_en_q;
  assign ctrl_o     = k_q[AW-1];
  assign addr_o     = k_q;

endmodule

// File: rtl/fft_stage_sequencer.sv
// FFT stage III/IV timing sequencer: one FSM driving both stage timers and the output-valid pipe.
// Optional FFT_SEQ_FRAME_CNT_EN adds the output frame counter and start-of-frame pulse.
module fft_stage_sequencer
  import fft_seq_pkg::*;
#(
  parameter int DLY3    = DLY3_DEF,
  parameter int DLY4    = DLY4_DEF,
  parameter int FRAME_W = FRAME_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_stage_sequencer_if.master seq_if
);

  localparam int A3W = addr_w(DLY3);
  localparam int A4W = addr_w(DLY4);

  seq_state_e     state_q, state_d;
  logic           in_en_s;
  logic           fill3_last_s, fill4_last_s;
  logic           en3_d_s, en4_d_s;
  logic           stage4_en_s;
  logic [A4W-1:0] addr4_s;
  logic           busy_q, out_valid_q, out_valid_d;

  assign in_en_s = seq_if.in_enable;

  // next-state; any low in_enable aborts straight to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_en_s) state_d = FILL3; else state_d = IDLE;
      FILL3:   if (!in_en_s) state_d = IDLE;
               else if (fill3_last_s) state_d = FILL4;
               else state_d = FILL3;
      FILL4:   if (!in_en_s) state_d = IDLE;
               else if (fill4_last_s) state_d = RUN;
               else state_d = FILL4;
      RUN:     if (!in_en_s) state_d = IDLE; else state_d = RUN;
      default: state_d = IDLE;
    endcase
    en3_d_s     = (state_d == FILL4) || (state_d == RUN);
    en4_d_s     = (state_d == RUN);
    out_valid_d = stage4_en_s && in_en_s;
  end

  // FSM state, busy and output-valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != IDLE);
      out_valid_q <= out_valid_d;
    end
  end

  // Edge 1 is sampled in IDLE, so FILL3 only needs DLY3-1 more edges.
  fft_seq_stage_timer #(.DLY(DLY3), .FILL_LAST(DLY3 - 2)) u_timer3 (
    .clk         (clk),
    .rst         (rst),
    .fill_i      (state_q == FILL3),
    .en_d_i      (en3_d_s),
    .fill_last_o (fill3_last_s),
    .stage_en_o  (seq_if.stage3_en),
    .ctrl_o      (seq_if.ctrl3),
    .addr_o      (seq_if.coeff_addr3)
  );

  fft_seq_stage_timer #(.DLY(DLY4), .FILL_LAST(DLY4 - 1)) u_timer4 (
    .clk         (clk),
    .rst         (rst),
    .fill_i      (state_q == FILL4),
    .en_d_i      (en4_d_s),
    .fill_last_o (fill4_last_s),
    .stage_en_o  (stage4_en_s),
    .ctrl_o      (seq_if.ctrl4),
    .addr_o      (addr4_s)
  );

  assign seq_if.stage4_en   = stage4_en_s;
  assign seq_if.coeff_addr4 = addr4_s;
  assign seq_if.out_valid   = out_valid_q;
  assign seq_if.busy        = busy_q;

`ifdef FFT_SEQ_FRAME_CNT_EN
  logic [A4W-1:0]     addr4_dly_q;
  logic               sof_q;
  logic [FRAME_W-1:0] frame_q;

  // frame tracking aligned to out_valid; frame_q survives aborts, only rst clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr4_dly_q <= '0;
      sof_q       <= 1'b0;
      frame_q     <= '0;
    end else begin
      addr4_dly_q <= addr4_s;
      sof_q       <= out_valid_d && (addr4_s == '0);
      if (out_valid_q && (addr4_dly_q == {A4W{1'b1}})) begin
        frame_q <= frame_q + FRAME_W'(1);
      end else begin
        frame_q <= frame_q;
      end
    end
  end

  assign seq_if.sof       = sof_q;
  assign seq_if.frame_cnt = frame_q;
`else
  assign seq_if.sof       = 1'b0;
  assign seq_if.frame_cnt = '0;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer (DLY3=8, DLY4=4); define FFT_SEQ_FRAME_CNT_EN for frame checks.
module tb_fft_stage_sequencer;
  import fft_seq_pkg::*;

`ifdef FFT_SEQ_FRAME_CNT_EN
  localparam int FW = 2;
`else
  localparam int FW = 16;
`endif
  localparam int D3  = 8;
  localparam int D4  = 4;
  localparam int A3W = addr_w(D3);
  localparam int A4W = addr_w(D4);

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.A3W(A3W), .A4W(A4W), .FRAME_W(FW)) sif ();

  fft_stage_sequencer #(.DLY3(D3), .DLY4(D4), .FRAME_W(FW)) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_if (sif)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {18'd0, sif.stage3_en, sif.ctrl3, sif.coeff_addr3, sif.stage4_en,
            sif.ctrl4, sif.coeff_addr4, sif.out_valid, sif.busy, sif.sof};
  endfunction

  function automatic logic [31:0] pack_exp(input int e3, input int c3, input int a3, input int e4,
                                           input int c4, input int a4, input int ov, input int bz,
                                           input int sf);
    logic [31:0] v;
    v = {18'd0, e3[0], c3[0], a3[3:0], e4[0], c4[0], a4[2:0], ov[0], bz[0], sf[0]};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // in_enable already high and DUT idle; edge n is the n-th edge with in_enable sampled high
  task automatic fill_check(input string tag, input int nmax, input bit chk_frame);
    int e3, c3, a3, e4, c4, a4, ov, sf, fr;
    for (int n = 1; n <= nmax; n++) begin
      step();
      e3 = (n >= 8)  ? 1 : 0;
      e4 = (n >= 12) ? 1 : 0;
      ov = (n >= 13) ? 1 : 0;
      a3 = e3 ? (n - 8) % 16 : 0;
      c3 = e3 ? ((n - 8) / 8) % 2 : 0;
      a4 = e4 ? (n - 12) % 8 : 0;
      c4 = e4 ? ((n - 12) / 4) % 2 : 0;
`ifdef FFT_SEQ_FRAME_CNT_EN
      sf = (ov == 1 && ((n - 13) % 8) == 0) ? 1 : 0;
      fr = ov ? ((n - 13) / 8) % (1 << FW) : 0;
`else
      sf = 0;
      fr = 0;
`endif
      check_val($sformatf("%s e%0d", tag, n), outs(), pack_exp(e3, c3, a3, e4, c4, a4, ov, 1, sf));
      if (chk_frame) begin
        check_val($sformatf("%s frame e%0d", tag, n), 32'(sif.frame_cnt), 32'(fr));
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    sif.in_enable = 1'b1;
    repeat (3) step();
    check_val("reset outs", outs(), 32'd0);
    check_val("reset frame", 32'(sif.frame_cnt), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    fill_check("run", 78, 1'b1);

    sif.in_enable = 1'b0;
    step();
    check_val("abort run", outs(), 32'd0);
    sif.in_enable = 1'b1;
    fill_check("refill1", 11, 1'b0);

    sif.in_enable = 1'b0;
    step();
    check_val("abort fill4", outs(), 32'd0);
    step();
    check_val("idle hold", outs(), 32'd0);
    sif.in_enable = 1'b1;
    fill_check("refill2", 16, 1'b0);

    sif.in_enable = 1'b0;
    step();
    check_val("glitch abort", outs(), 32'd0);
    sif.in_enable = 1'b1;
    fill_check("refill3", 14, 1'b0);

    #3;
    rst = 1'b1;
    #1;
    check_val("async rst outs", outs(), 32'd0);
    check_val("async rst frame", 32'(sif.frame_cnt), 32'd0);
    rst = 1'b0;
    fill_check("post rst", 53, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
